// File: rtl/piece_move_sched.sv
// Falling-piece sequencer: arbitrates rotate/left/right/down moves, runs each candidate past the
// playfield collision checker, then commits, locks or respawns. Optional HARD_DROP_EN adds btnHd.
module piece_move_sched #(
    parameter int COLS      = 10,
    parameter int ROWS      = 20,
    parameter int SPAWN_COL = 4,
    parameter int GRAV_DIV  = 75_000_000
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       start,
    input  logic       btnL,
    input  logic       btnR,
    input  logic       btnU,
    input  logic       btnD,
`ifdef HARD_DROP_EN
    input  logic       btnHd,
`endif
    output logic       chk_req,
    output logic [3:0] chk_col,
    output logic [4:0] chk_row,
    output logic [1:0] chk_rot,
    output logic [2:0] chk_block,
    input  logic       chk_ack,
    input  logic       chk_ok,
    output logic [3:0] col,
    output logic [4:0] row,
    output logic [1:0] rot,
    output logic [2:0] block,
    output logic       lock,
    output logic       game_over
);
    localparam int GW = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
    localparam logic [3:0] LAST_COL = 4'(COLS - 1);

    typedef enum logic [2:0] {IDLE, SPAWN, WAIT, CHECK, LOCK, OVER} state_t;
    typedef enum logic [1:0] {MV_ROT, MV_L, MV_R, MV_DN} mv_t;
    typedef struct packed {
        logic [2:0] block;
        logic [1:0] rot;
        logic [4:0] row;
        logic [3:0] col;
    } piece_t;

    state_t        state;
    mv_t           mv;
    piece_t        cur, cand, spawn_pc, home_pc;
    logic [2:0]    lfsr;
    logic [GW-1:0] grav_cnt;
    logic          p_rot, p_l, p_r, p_dn;
    logic          active, run_grav, grav_hit, hd_busy;

`ifdef HARD_DROP_EN
    logic hd, p_hd;
    assign hd_busy = hd;
`else
    assign hd_busy = 1'b0;
`endif

    // The new block is drawn from the LFSR at the moment the spawn candidate is loaded.
    always_comb begin
        spawn_pc = '{block: lfsr - 3'd1, rot: 2'd0, row: 5'd0, col: 4'(SPAWN_COL)};
        home_pc  = '{block: 3'd0, rot: 2'd0, row: 5'd0, col: 4'(SPAWN_COL)};
    end

    assign active   = (state != IDLE) && (state != OVER);
    assign run_grav = ((state == WAIT) || (state == CHECK)) && !hd_busy;
    assign grav_hit = grav_cnt == GW'(GRAV_DIV - 1);

    assign chk_col   = cand.col;
    assign chk_row   = cand.row;
    assign chk_rot   = cand.rot;
    assign chk_block = cand.block;
    assign col       = cur.col;
    assign row       = cur.row;
    assign rot       = cur.rot;
    assign block     = cur.block;

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            mv        <= MV_ROT;
            cur       <= home_pc;
            cand      <= home_pc;
            chk_req   <= 1'b0;
            lock      <= 1'b0;
            game_over <= 1'b0;
            p_rot     <= 1'b0;
            p_l       <= 1'b0;
            p_r       <= 1'b0;
            p_dn      <= 1'b0;
            grav_cnt  <= '0;
            lfsr      <= 3'b001;
`ifdef HARD_DROP_EN
            hd        <= 1'b0;
            p_hd      <= 1'b0;
`endif
        end else begin
            lfsr <= {lfsr[1:0], lfsr[2] ^ lfsr[1]};
            lock <= 1'b0;

            // Pulse capture; state-machine clears below take precedence.
            if (active && !hd_busy) begin
                if (btnU) p_rot <= 1'b1;
                if (btnL) p_l   <= 1'b1;
                if (btnR) p_r   <= 1'b1;
`ifdef HARD_DROP_EN
                if (btnHd) p_hd <= 1'b1;
`endif
            end
            if (active && !hd_busy && btnD) begin
                p_dn     <= 1'b1;
                grav_cnt <= '0;
            end else if (run_grav) begin
                if (grav_hit) begin
                    p_dn     <= 1'b1;
                    grav_cnt <= '0;
                end else begin
                    grav_cnt <= grav_cnt + GW'(1);
                end
            end

            if (start && (state == SPAWN || state == WAIT || state == CHECK || state == LOCK)) begin
                // Abandon: the request drops for a cycle before the fresh spawn is issued.
                chk_req  <= 1'b0;
                p_rot    <= 1'b0;
                p_l      <= 1'b0;
                p_r      <= 1'b0;
                p_dn     <= 1'b0;
                grav_cnt <= '0;
`ifdef HARD_DROP_EN
                hd       <= 1'b0;
                p_hd     <= 1'b0;
`endif
                state    <= SPAWN;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        cand    <= spawn_pc;
                        chk_req <= 1'b1;
                        state   <= SPAWN;
                    end
                    SPAWN: begin
                        if (!chk_req) begin
                            cand    <= spawn_pc;
                            chk_req <= 1'b1;
                        end else if (chk_ack) begin
                            chk_req <= 1'b0;
                            if (chk_ok) begin
                                cur   <= cand;
                                state <= WAIT;
                            end else begin
                                game_over <= 1'b1;
                                state     <= OVER;
                            end
                        end
                    end
                    WAIT: begin
`ifdef HARD_DROP_EN
                        if (hd || p_hd) begin
                            p_hd <= 1'b0;
                            hd   <= 1'b1;
                            if (cur.row == LAST_ROW) begin
                                state <= LOCK;
                            end else begin
                                cand     <= cur;
                                cand.row <= cur.row + 5'd1;
                                mv       <= MV_DN;
                                chk_req  <= 1'b1;
                                state    <= CHECK;
                            end
                        end else
`endif
                        if (p_rot) begin
                            p_rot    <= 1'b0;
                            cand     <= cur;
                            cand.rot <= cur.rot + 2'd1;
                            mv       <= MV_ROT;
                            chk_req  <= 1'b1;
                            state    <= CHECK;
                        end else if (p_l) begin
                            p_l <= 1'b0;
                            if (cur.col != 4'd0) begin
                                cand     <= cur;
                                cand.col <= cur.col - 4'd1;
                                mv       <= MV_L;
                                chk_req  <= 1'b1;
                                state    <= CHECK;
                            end
                        end else if (p_r) begin
                            p_r <= 1'b0;
                            if (cur.col != LAST_COL) begin
                                cand     <= cur;
                                cand.col <= cur.col + 4'd1;
                                mv       <= MV_R;
                                chk_req  <= 1'b1;
                                state    <= CHECK;
                            end
                        end else if (p_dn) begin
                            p_dn <= 1'b0;
                            if (cur.row == LAST_ROW) begin
                                state <= LOCK;
                            end else begin
                                cand     <= cur;
                                cand.row <= cur.row + 5'd1;
                                mv       <= MV_DN;
                                chk_req  <= 1'b1;
                                state    <= CHECK;
                            end
                        end
                    end
                    CHECK: if (chk_ack) begin
                        chk_req <= 1'b0;
                        if (chk_ok) begin
                            cur   <= cand;
                            state <= WAIT;
                        end else if (mv == MV_DN) begin
                            state <= LOCK;
                        end else begin
                            state <= WAIT;
                        end
                    end
                    LOCK: begin
                        lock     <= 1'b1;
                        p_rot    <= 1'b0;
                        p_l      <= 1'b0;
                        p_r      <= 1'b0;
                        p_dn     <= 1'b0;
                        grav_cnt <= '0;
`ifdef HARD_DROP_EN
                        hd       <= 1'b0;
                        p_hd     <= 1'b0;
`endif
                        cand     <= spawn_pc;
                        chk_req  <= 1'b1;
                        state    <= SPAWN;
                    end
                    OVER: if (start) begin
                        game_over <= 1'b0;
                        cand      <= spawn_pc;
                        chk_req   <= 1'b1;
                        state     <= SPAWN;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_piece_move_sched.sv
// Directed bench for piece_move_sched: a hand-driven checker on the main instance and a
// fast-gravity instance with an auto-acking checker.
module tb_piece_move_sched;
    logic       pclk = 1'b0, rst = 1'b0, start = 1'b0;
    logic       btnL = 1'b0, btnR = 1'b0, btnU = 1'b0, btnD = 1'b0;
    logic       chk_ack = 1'b0, chk_ok = 1'b0;
    logic       chk_req, lock, game_over;
    logic [3:0] chk_col, col;
    logic [4:0] chk_row, row;
    logic [1:0] chk_rot, rot;
    logic [2:0] chk_block, block;

    logic       g_start = 1'b0, g_ack = 1'b0;
    logic       g_req, g_lock, g_over;
    logic [3:0] g_chk_col, g_col;
    logic [4:0] g_chk_row, g_row;
    logic [1:0] g_chk_rot, g_rot;
    logic [2:0] g_chk_block, g_block;

    int total = 0, bad = 0;

    always #5 pclk = ~pclk;

    piece_move_sched #(.GRAV_DIV(1000)) u_dut (
        .pclk(pclk), .rst(rst), .start(start),
        .btnL(btnL), .btnR(btnR), .btnU(btnU), .btnD(btnD),
`ifdef HARD_DROP_EN
        .btnHd(1'b0),
`endif
        .chk_req(chk_req), .chk_col(chk_col), .chk_row(chk_row), .chk_rot(chk_rot),
        .chk_block(chk_block), .chk_ack(chk_ack), .chk_ok(chk_ok),
        .col(col), .row(row), .rot(rot), .block(block), .lock(lock), .game_over(game_over)
    );

    piece_move_sched #(.GRAV_DIV(8)) u_grav (
        .pclk(pclk), .rst(rst), .start(g_start),
        .btnL(1'b0), .btnR(1'b0), .btnU(1'b0), .btnD(1'b0),
`ifdef HARD_DROP_EN
        .btnHd(1'b0),
`endif
        .chk_req(g_req), .chk_col(g_chk_col), .chk_row(g_chk_row), .chk_rot(g_chk_rot),
        .chk_block(g_chk_block), .chk_ack(g_ack), .chk_ok(1'b1),
        .col(g_col), .row(g_row), .rot(g_rot), .block(g_block), .lock(g_lock), .game_over(g_over)
    );

    // Always-accepting checker: acks in the first cycle it sees a request.
    initial forever begin
        @(posedge pclk);
        #1;
        g_ack = g_req && !g_ack;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic press(input logic l, input logic r, input logic u, input logic d);
        btnL = l; btnR = r; btnU = u; btnD = d;
        step();
        btnL = 1'b0; btnR = 1'b0; btnU = 1'b0; btnD = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!chk_req && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_req"}, 32'(chk_req), 32'd1);
    endtask

    // Wait for a request, check its candidate (col,row,rot), answer with ok, step past the ack.
    task automatic serve(input string tag, input logic ok, input int ec, input int er, input int et);
        wait_req(tag);
        chk({tag, "_cand"}, 32'({chk_col, chk_row, chk_rot}), 32'({4'(ec), 5'(er), 2'(et)}));
        chk_ack = 1'b1;
        chk_ok  = ok;
        step();
        chk_ack = 1'b0;
        chk_ok  = 1'b0;
    endtask

    task automatic quiet(input string tag, input int n);
        int c = 0;
        repeat (n) begin
            if (chk_req) c++;
            step();
        end
        chk(tag, 32'(c), 32'd0);
    endtask

    task automatic count_lock(input int n, output int c);
        c = 0;
        repeat (n) begin
            if (lock) c++;
            step();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int nl, t, t1, t2, reqs, n;
        logic [4:0] prev;

        // Reset values
        step(); step();
        chk("rst_req", 32'(chk_req), 32'd0);
        chk("rst_pos", 32'({col, row, rot, block}), 32'({4'd4, 5'd0, 2'd0, 3'd0}));
        chk("rst_flags", 32'({lock, game_over}), 32'd0);

        // First spawn: LFSR is still 001, so the block is 0
        rst = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        chk("spawn_req", 32'(chk_req), 32'd1);
        chk("spawn_block", 32'(chk_block), 32'd0);
        serve("spawn", 1'b1, 4, 0, 0);
        chk("spawn_commit", 32'({col, row, rot, block}), 32'({4'd4, 5'd0, 2'd0, 3'd0}));

        // Minimum latency: pulse -> req -> ack -> commit over three edges
        press(1'b0, 1'b1, 1'b0, 1'b0);
        step();
        chk("lat_req", 32'({chk_req, chk_col}), 32'({1'b1, 4'd5}));
        chk_ack = 1'b1; chk_ok = 1'b1;
        step();
        chk_ack = 1'b0; chk_ok = 1'b0;
        chk("lat_commit", 32'(col), 32'd5);
        chk("lat_req_drop", 32'(chk_req), 32'd0);

        // Simultaneous pulses during CHECK are served rot, left, right
        press(1'b0, 1'b1, 1'b0, 1'b0);
        wait_req("pri_hold");
        press(1'b1, 1'b1, 1'b1, 1'b0);
        serve("pri_cur", 1'b1, 6, 0, 0);
        serve("pri_rot", 1'b1, 6, 0, 1);
        serve("pri_l", 1'b1, 5, 0, 1);
        serve("pri_r", 1'b1, 6, 0, 1);
        chk("pri_final", 32'({col, rot}), 32'({4'd6, 2'd1}));

        // Left wall and rotation wrap
        start = 1'b1; step(); start = 1'b0;
        serve("rs1", 1'b1, 4, 0, 0);
        for (int i = 3; i >= 0; i--) begin
            press(1'b1, 1'b0, 1'b0, 1'b0);
            serve("walk_l", 1'b1, i, 0, 0);
        end
        press(1'b1, 1'b0, 1'b0, 1'b0);
        quiet("wall_noreq", 6);
        chk("wall_col", 32'(col), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            press(1'b0, 1'b0, 1'b1, 1'b0);
            serve("rot_step", 1'b1, 0, 0, i);
        end
        press(1'b0, 1'b0, 1'b1, 1'b0);
        serve("rot_wrap", 1'b1, 0, 0, 0);
        chk("rot_wrap_out", 32'(rot), 32'd0);

        // Down rejected at row 7 locks exactly once and respawns
        start = 1'b1; step(); start = 1'b0;
        serve("rs2", 1'b1, 4, 0, 0);
        for (int i = 1; i <= 7; i++) begin
            press(1'b0, 1'b0, 1'b0, 1'b1);
            serve("drop", 1'b1, 4, i, 0);
        end
        press(1'b0, 1'b0, 1'b0, 1'b1);
        serve("dn_rej", 1'b0, 4, 8, 0);
        chk("dn_rej_row", 32'(row), 32'd7);
        count_lock(3, nl);
        chk("dn_rej_lock", 32'(nl), 32'd1);
        serve("respawn", 1'b1, 4, 0, 0);
        chk("respawn_row", 32'(row), 32'd0);

        // Left reject: discarded, no lock, still accepting moves
        press(1'b1, 1'b0, 1'b0, 1'b0);
        serve("l_rej", 1'b0, 3, 0, 0);
        chk("l_rej_col", 32'(col), 32'd4);
        count_lock(4, nl);
        chk("l_rej_nolock", 32'(nl), 32'd0);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        serve("after_rej", 1'b1, 5, 0, 0);

        // Spawn rejected -> game over; buttons ignored; start recovers
        start = 1'b1; step(); start = 1'b0;
        serve("sp_rej", 1'b0, 4, 0, 0);
        chk("over_set", 32'(game_over), 32'd1);
        press(1'b1, 1'b1, 1'b1, 1'b1);
        quiet("over_noreq", 5);
        chk("over_hold", 32'(game_over), 32'd1);
        start = 1'b1; step(); start = 1'b0;
        chk("over_clear", 32'({game_over, chk_req}), 32'({1'b0, 1'b1}));
        serve("restart", 1'b1, 4, 0, 0);

        // Async reset in the middle of a check
        press(1'b0, 1'b1, 1'b0, 1'b0);
        wait_req("mid");
        #2;
        rst = 1'b0;
        #1;
        chk("arst_req", 32'(chk_req), 32'd0);
        chk("arst_pos", 32'({col, row, rot, block}), 32'({4'd4, 5'd0, 2'd0, 3'd0}));
        step();
        rst = 1'b1;

        // Gravity every 8 cycles, bottom lock without a request, respawn
        g_start = 1'b1; step(); g_start = 1'b0;
        t = 0; t1 = 0; t2 = 0; prev = g_row;
        while (g_row != 5'd19 && t < 400) begin
            step();
            t++;
            if (g_row != prev) begin
                if (g_row == 5'd1) t1 = t;
                if (g_row == 5'd2) t2 = t;
                prev = g_row;
            end
        end
        chk("grav_period", 32'(t2 - t1), 32'd8);
        chk("grav_row19", 32'(g_row), 32'd19);
        reqs = 0; n = 0;
        while (!g_lock && n < 40) begin
            if (g_req) reqs++;
            step();
            n++;
        end
        chk("grav_lock", 32'(g_lock), 32'd1);
        chk("grav_noreq", 32'(reqs), 32'd0);
        chk("grav_spawn_cand", 32'({g_chk_col, g_chk_row}), 32'({4'd4, 5'd0}));
        n = 0;
        while (g_row != 5'd0 && n < 20) begin
            step();
            n++;
        end
        chk("grav_respawn", 32'(g_row), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/piece_move_sched.md
Name: piece_move_sched

Overview:
- Sequences the falling-piece state (block type, rotation, grid column/row) that feeds the rectangle/piece drawing stage and its position controller.
- Arbitrates four move sources: rotate, left, right, and down (soft drop or gravity tick).
- Submits one candidate move at a time to the playfield collision checker over a req/ack handshake.
- Commits, discards or locks the piece based on the result, then spawns the next piece.

Parameters:
- COLS, 10, playfield width in cells.
- ROWS, 20, playfield height in cells.
- SPAWN_COL, 4, spawn column.
- GRAV_DIV, 75_000_000, pclk cycles per gravity tick (1 s at 75 MHz).

Ports:
- pclk  input  1  pixel clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; starts or restarts a game.
- btnL  input  1  one-cycle pulse, already debounced: move left.
- btnR  input  1  one-cycle pulse: move right.
- btnU  input  1  one-cycle pulse: rotate clockwise.
- btnD  input  1  one-cycle pulse: soft drop.
- chk_req  output  1  candidate valid; held until chk_ack.
- chk_col  output  4  candidate column.
- chk_row  output  5  candidate row.
- chk_rot  output  2  candidate rotation.
- chk_block  output  3  candidate block type.
- chk_ack  input  1  checker result valid; one-cycle pulse.
- chk_ok  input  1  candidate fits; sampled only with chk_ack.
- col  output  4  committed column.
- row  output  5  committed row.
- rot  output  2  committed rotation.
- block  output  3  committed block, 0..6.
- lock  output  1  one-cycle pulse when the piece locks.
- game_over  output  1  level; held until start.

Behaviour:
- Reset (rst=0, async): state IDLE; col=SPAWN_COL, row=0, rot=0, block=0; chk_req=0, lock=0, game_over=0; pending flags and gravity counter cleared; LFSR=3'b001.
- LFSR: 3-bit maximal, advances every cycle, never 0. Next block = LFSR-1, sampled in SPAWN.
- Pending flags: p_rot, p_l, p_r, p_dn. Set by the matching pulse in any state except IDLE and OVER; 1-deep, so repeats while set are dropped.
- Gravity: counter runs in WAIT and CHECK. At GRAV_DIV-1 it sets p_dn and wraps to 0. btnD also sets p_dn and clears the counter.
- IDLE: on start -> SPAWN.
- SPAWN:
  - Candidate = (SPAWN_COL, row 0, rot 0, new block); issue it to the checker.
  - ok: commit -> WAIT.
  - not ok: game_over=1 -> OVER.
- WAIT: grant the highest-priority pending flag, clear it, build the candidate, go to CHECK. Priority: rot > l > r > dn.
  - Rotate: rot+1, wraps 3->0.
  - Left at col=0: dropped locally, no request issued; stay in WAIT.
  - Right at col=COLS-1: dropped locally, no request; stay in WAIT.
  - Down at row=ROWS-1: no request; -> LOCK.
- CHECK:
  - chk_req=1 with candidate stable until chk_ack.
  - chk_ack & chk_ok: commit; outputs update the cycle after ack; -> WAIT.
  - chk_ack & !chk_ok: down move -> LOCK; any other move is discarded -> WAIT.
  - chk_req drops the cycle after ack.
  - chk_ack while chk_req=0 is ignored.
  - Pulses arriving during CHECK stay pending.
- LOCK: lock=1 for one cycle; clear all pending flags and the gravity counter; -> SPAWN.
- OVER: ignore the buttons. On start: game_over=0 -> SPAWN.
- start in WAIT/CHECK/LOCK: abandon the current piece, drop chk_req, clear the pending flags -> SPAWN. start has priority over chk_ack in the same cycle.
- Minimum move latency: pulse -> committed output in 3 cycles when the checker acks in the cycle after req.

Optional Feature:
- HARD_DROP_EN defined: adds input btnHd (one-cycle pulse) with priority above rot.
  - Enters a repeat-down mode: issues successive down candidates.
  - Each ok result commits and continues; the first reject, or reaching row ROWS-1, -> LOCK.
  - All other pulses during hard drop are discarded, and gravity is frozen.
- HARD_DROP_EN undefined: no btnHd port and no hard-drop logic.

Test Plan:
- Reset then start, checker ok with 1-cycle latency -> chk_req with col=4 row=0 rot=0, block=0 (LFSR=1 at SPAWN if start is applied the cycle after reset release); then col=4 row=0 committed, state WAIT.
- GRAV_DIV=8, no buttons, all ok -> row increments once every 8 cycles (±handshake); at row=19 the next tick gives lock pulse without a chk_req, then a respawn at row 0.
- btnL, btnR, btnU in the same cycle while in CHECK -> after the current ack: rotate, then left, then right, each as a separate req, in that order.
- col=0, btnL -> no chk_req, col stays 0; rot=3, btnU, ok -> rot=0.
- Down candidate rejected (chk_ok=0) at row=7 -> row stays 7, lock=1 exactly one cycle, new spawn request follows; a left reject instead -> no lock.
- Spawn rejected -> game_over=1, buttons ignored; start -> game_over=0 and a new spawn req. rst pulled low mid-CHECK -> chk_req=0 immediately, all outputs at reset values.
